fir_filter: RTL and testbench

//   32-tap low-pass FIR at the front of the frequency-analysis chain.

---
 rtl/fas_pkg.sv | 29 ++
 rtl/fir_mac8.sv | 38 +++
 rtl/fir_filter.sv | 94 +++++++++
 tb/tb_fir_filter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared constants, types and coefficient table for the frequency-analysis chain.
package fas_pkg;

    localparam int unsigned FIR_TAPS       = 32;
    localparam int unsigned FIR_DW         = 16;
    localparam int unsigned FIR_CW         = 20;
    localparam int unsigned FIR_FRAC_SHIFT = 16;
    localparam int unsigned FIR_LANES      = 8;
    localparam int unsigned FIR_PW         = FIR_DW + FIR_CW;
    localparam int unsigned FIR_SW         = FIR_PW + 3;
    localparam int unsigned FIR_AW         = FIR_SW + 2;

    typedef logic signed [FIR_DW-1:0] fir_sample_t;
    typedef logic signed [FIR_CW-1:0] fir_coef_t;
    typedef fir_coef_t fir_coef_tab_t [0:FIR_TAPS-1];

    // Symmetric low-pass taps, Q4.16 (DC gain about 0.67)
    localparam fir_coef_tab_t FIR_COEF = '{
        -20'sd64,   -20'sd96,   -20'sd128,  -20'sd144,
        -20'sd112,   20'sd0,     20'sd224,   20'sd560,
         20'sd992,   20'sd1504,  20'sd2064,  20'sd2624,
         20'sd3136,  20'sd3552,  20'sd3840,  20'sd3968,
         20'sd3968,  20'sd3840,  20'sd3552,  20'sd3136,
         20'sd2624,  20'sd2064,  20'sd1504,  20'sd992,
         20'sd560,   20'sd224,   20'sd0,    -20'sd112,
        -20'sd144,  -20'sd128,  -20'sd96,   -20'sd64
    };

endpackage

// File: rtl/fir_mac8.sv
// Eight-lane multiply stage followed by a registered partial-sum stage.
module fir_mac8
    import fas_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic signed [FIR_DW-1:0] x    [0:FIR_LANES-1],
    input  logic signed [FIR_CW-1:0] coef [0:FIR_LANES-1],
    output logic signed [FIR_SW-1:0] psum
);

    logic signed [FIR_PW-1:0] prod [0:FIR_LANES-1];
    logic signed [FIR_SW-1:0] sum_c;

    // Product registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < int'(FIR_LANES); k++) prod[k] <= '0;
        end else begin
            for (int k = 0; k < int'(FIR_LANES); k++)
                prod[k] <= FIR_PW'(x[k]) * FIR_PW'(coef[k]);
        end
    end

    // Sign-extended sum of the eight products
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < int'(FIR_LANES); k++)
            sum_c = sum_c + FIR_SW'(prod[k]);
    end

    // Partial-sum register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) psum <= '0;
        else        psum <= sum_c;
    end

endmodule

// File: rtl/fir_filter.sv
// 32-tap pipelined FIR, Q8.8 in/out, three-cycle latency, one sample per clock.
module fir_filter
    import fas_pkg::*;
#(
    parameter fir_coef_tab_t COEF = FIR_COEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              data_valid,
    input  logic [FIR_DW-1:0] data,
    output logic              fir_valid,
    output logic [FIR_DW-1:0] fir_d
);

    localparam int unsigned TAPS = FIR_TAPS;
    localparam int unsigned MACS = TAPS / FIR_LANES;
    localparam int unsigned WCW  = $clog2(TAPS);
    localparam logic signed [FIR_AW-1:0] SAT_MAX = FIR_AW'(32767);
    localparam logic signed [FIR_AW-1:0] SAT_MIN = FIR_AW'(-32768);

    fir_sample_t              x [0:TAPS-1];
    logic [WCW-1:0]           wcnt;
    logic                     v0, v1, v2;
    logic signed [FIR_SW-1:0] psum [0:MACS-1];
    logic signed [FIR_AW-1:0] acc_c;
    logic signed [FIR_AW-1:0] r_c;
    logic [FIR_DW-1:0]        sat_c;

    // Delay line shifts only on accepted samples
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(TAPS); i++) x[i] <= '0;
        end else if (data_valid) begin
            x[0] <= fir_sample_t'(data);
            for (int i = 1; i < int'(TAPS); i++) x[i] <= x[i-1];
        end
    end

    // Warm-up counter and valid pipeline; v0 uses the pre-update count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wcnt <= '0;
            v0   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            v0 <= data_valid && (wcnt == WCW'(TAPS - 1));
            v1 <= v0;
            v2 <= v1;
            if (data_valid && (wcnt != WCW'(TAPS - 1)))
                wcnt <= wcnt + WCW'(1);
        end
    end

    // Four 8-tap MAC lanes
    for (genvar g = 0; g < MACS; g++) begin : g_mac
        fir_sample_t xs [0:FIR_LANES-1];
        fir_coef_t   cs [0:FIR_LANES-1];
        for (genvar j = 0; j < FIR_LANES; j++) begin : g_lane
            assign xs[j] = x[g*FIR_LANES + j];
            assign cs[j] = COEF[g*FIR_LANES + j];
        end
        fir_mac8 u_mac (
            .CLK  (CLK),
            .RST_N(RST_N),
            .x    (xs),
            .coef (cs),
            .psum (psum[g])
        );
    end

    // Final sum, floor rescale to Q8.8 and saturation
    always_comb begin
        acc_c = '0;
        for (int g = 0; g < int'(MACS); g++)
            acc_c = acc_c + FIR_AW'(psum[g]);
        r_c = acc_c >>> FIR_FRAC_SHIFT;
        if (r_c > SAT_MAX)      sat_c = 16'h7FFF;
        else if (r_c < SAT_MIN) sat_c = 16'h8000;
        else                    sat_c = r_c[FIR_DW-1:0];
    end

    // Output register; fir_d holds between valid pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fir_valid <= 1'b0;
            fir_d     <= '0;
        end else begin
            fir_valid <= v2;
            if (v2) fir_d <= sat_c;
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: tables, corner sequences and a reference model.
module tb_fir_filter;
    import fas_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        data_valid;
    logic [15:0] data;
    logic        fir_valid, fir_valid_s;
    logic [15:0] fir_d, fir_d_s;

    localparam fir_coef_tab_t SAT_COEF = '{default: 20'sh10000};

    always #5 CLK = ~CLK;

    fir_filter u_dut (
        .CLK(CLK), .RST_N(RST_N), .data_valid(data_valid), .data(data),
        .fir_valid(fir_valid), .fir_d(fir_d)
    );

    fir_filter #(.COEF(SAT_COEF)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .data_valid(data_valid), .data(data),
        .fir_valid(fir_valid_s), .fir_d(fir_d_s)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { int cyc; int y; int ys; } exp_t;
    int   hist[$];
    exp_t expq[$];
    int   naccept = 0;
    int   cyc = 0;
    int   last_y = 0, last_ys = 0;
    int   outs = 0;

    typedef struct { logic dv; logic [15:0] d; logic ev; int ed; } vec_t;
    vec_t tbl [44];
    int   imp [16] = '{-1, -1, -1, -1, -1, 0, 0, 2, 3, 5, 8, 10, 12, 13, 15, 15};

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // Filter output computed from the last 32 accepted samples, newest first
    function automatic int model_y(input bit unity);
        longint acc = 0;
        longint r;
        for (int k = 0; k < hist.size(); k++) begin
            longint c = unity ? 64'sd65536 : longint'(FIR_COEF[k]);
            acc += c * longint'(hist[k]);
        end
        r = acc >>> 16;
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return int'(r);
    endfunction

    task automatic compare_outputs();
        bit ev = (expq.size() > 0) && (expq[0].cyc == cyc);
        if (ev) begin
            last_y  = expq[0].y;
            last_ys = expq[0].ys;
            void'(expq.pop_front());
        end
        if (fir_valid) outs++;
        check("valid", longint'(fir_valid), longint'(ev));
        check("data", $signed(fir_d), last_y);
        check("sat_valid", longint'(fir_valid_s), longint'(ev));
        check("sat_data", $signed(fir_d_s), last_ys);
    endtask

    task automatic tick(input logic v, input logic [15:0] d);
        data_valid = v;
        data       = d;
        @(posedge CLK);
        cyc++;
        if (RST_N && v) begin
            hist.push_front(int'($signed(d)));
            if (hist.size() > 32) void'(hist.pop_back());
            naccept++;
            if (naccept >= 32) expq.push_back('{cyc + 3, model_y(1'b0), model_y(1'b1)});
        end
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic do_reset();
        RST_N      = 1'b0;
        data_valid = 1'b0;
        data       = '0;
        #1;
        check("rst_valid", longint'(fir_valid), 0);
        check("rst_data", longint'(fir_d), 0);
        check("rst_sat_data", longint'(fir_d_s), 0);
        hist.delete();
        expq.delete();
        naccept = 0;
        last_y  = 0;
        last_ys = 0;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        compare_outputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int nv, o0;

        do_reset();

        // Warm-up: 31 silent samples, the 32nd appears three edges later
        for (int i = 0; i < 31; i++) begin
            tick(1'b1, 16'h0000);
            check("warm_quiet", longint'(fir_valid), 0);
        end
        tick(1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0000);
            check("warm_latency", longint'(fir_valid), (i == 2) ? 1 : 0);
        end

        // Impulse response table
        for (int i = 0; i < 44; i++) begin
            tbl[i].dv = 1'b1;
            tbl[i].d  = (i == 0) ? 16'h0100 : 16'h0000;
            if (i < 3) begin
                tbl[i].ev = 1'b0; tbl[i].ed = 0;
            end else if (i < 35) begin
                tbl[i].ev = 1'b1;
                tbl[i].ed = (i - 3 < 16) ? imp[i - 3] : imp[31 - (i - 3)];
            end else begin
                tbl[i].ev = 1'b1; tbl[i].ed = 0;
            end
        end
        for (int i = 0; i < 44; i++) begin
            tick(tbl[i].dv, tbl[i].d);
            check("imp_valid", longint'(fir_valid), longint'(tbl[i].ev));
            check("imp_data", $signed(fir_d), tbl[i].ed);
        end

        // Saturation with unity coefficients
        do_reset();
        for (int i = 0; i < 32; i++) tick(1'b1, 16'h7FFF);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        check("sat_hi", longint'(fir_d_s), 64'h7FFF);
        for (int i = 0; i < 32; i++) tick(1'b1, 16'h8000);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        check("sat_lo", longint'(fir_d_s), 64'h8000);

        // Random gaps at ~30% duty; one output per accepted sample
        nv = 0;
        o0 = outs;
        for (int i = 0; i < 300; i++) begin
            logic v = ($urandom_range(0, 99) < 30);
            if (v) nv++;
            tick(v, 16'($urandom()));
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        check("gap_count", outs - o0, nv);

        // Reset while outputs are flowing
        for (int i = 0; i < 10; i++) tick(1'b1, 16'($urandom()));
        do_reset();
        o0 = outs;
        for (int i = 0; i < 31; i++) tick(1'b1, 16'($urandom()));
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        check("rst_rewarm_quiet", outs - o0, 0);
        tick(1'b1, 16'($urandom()));
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        check("rst_rewarm_first", outs - o0, 1);

        // Long continuous random stream, then idle
        for (int i = 0; i < 2000; i++) tick(1'b1, 16'($urandom()));
        o0 = outs;
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        check("drain_count", outs - o0, 3);
        o0 = outs;
        for (int i = 0; i < 10; i++) tick(1'b0, 16'($urandom()));
        check("idle_quiet", outs - o0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
